// File: rtl/cdb_slot_scheduler.sv
// Latency-aware CDB issue arbiter: books future bus slots in a shift register and drives the CDB mux select.
// Optional conflict counter output o_conflict_cnt is built when CDB_SCHED_PERF_EN is defined.
module cdb_slot_scheduler #(
  parameter int INT_LAT    = 0,
  parameter int MEM_LAT    = 0,
  parameter int MULT_LAT   = 3,
  parameter int DIV_LAT    = 6,
  parameter int SLOT_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_ready_int,
  input  logic       i_ready_mult,
  input  logic       i_ready_div,
  input  logic       i_ready_mem,
  input  logic       i_div_exec_busy,
  output logic       o_issue_int,
  output logic       o_issue_mult,
  output logic       o_issue_div,
  output logic       o_issue_mem,
  output logic [3:0] o_cdb_sel,
  output logic       o_cdb_valid
`ifdef CDB_SCHED_PERF_EN
  ,
  output logic [15:0] o_conflict_cnt
`endif
);

  localparam int CW = $clog2(DIV_LAT + 1);

  logic [SLOT_DEPTH-1:0]      res_q, res_d;
  logic [SLOT_DEPTH-1:0][1:0] own_q, own_d;
  logic [CW-1:0]              div_cnt, div_cnt_d;
  logic                       rr_q, rr_d;

  logic hold;
  logic g_div, g_mult, g_int, g_mem;
  logic int_ok, mem_ok, lat0_grant;
  logic [3:0] sel;

  assign hold = i_rst | i_flush;

  always_comb begin
    g_div  = i_ready_div & ~i_div_exec_busy & (div_cnt == '0) & ~res_q[DIV_LAT] & ~hold;
    g_mult = i_ready_mult & ~res_q[MULT_LAT] & ~(g_div && (DIV_LAT == MULT_LAT)) & ~hold;
    int_ok = i_ready_int & ~res_q[INT_LAT] & ~hold
           & ~(g_div && (DIV_LAT == INT_LAT)) & ~(g_mult && (MULT_LAT == INT_LAT));
    mem_ok = i_ready_mem & ~res_q[MEM_LAT] & ~hold
           & ~(g_div && (DIV_LAT == MEM_LAT)) & ~(g_mult && (MULT_LAT == MEM_LAT));
    g_int  = int_ok;
    g_mem  = mem_ok;
    // Shared slot: the round-robin pointer picks one, the other simply stays ready.
    if ((INT_LAT == MEM_LAT) && int_ok && mem_ok) begin
      g_int = ~rr_q;
      g_mem = rr_q;
    end
    lat0_grant = (g_int && (INT_LAT == 0)) || (g_mem && (MEM_LAT == 0))
              || (g_mult && (MULT_LAT == 0));
  end

  always_comb begin
    res_d = {1'b0, res_q[SLOT_DEPTH-1:1]};
    own_d = {2'b00, own_q[SLOT_DEPTH-1:1]};
    for (int k = 1; k < SLOT_DEPTH; k++) begin
      if (g_int && (INT_LAT == k)) begin
        res_d[k-1] = 1'b1;
        own_d[k-1] = 2'd0;
      end
      if (g_div && (DIV_LAT == k)) begin
        res_d[k-1] = 1'b1;
        own_d[k-1] = 2'd1;
      end
      if (g_mult && (MULT_LAT == k)) begin
        res_d[k-1] = 1'b1;
        own_d[k-1] = 2'd2;
      end
      if (g_mem && (MEM_LAT == k)) begin
        res_d[k-1] = 1'b1;
        own_d[k-1] = 2'd3;
      end
    end
    if (g_div)
      div_cnt_d = CW'(DIV_LAT - 1);
    else if (div_cnt != '0)
      div_cnt_d = div_cnt - CW'(1);
    else
      div_cnt_d = '0;
    rr_d = rr_q;
    if (i_ready_int && i_ready_mem && (g_int ^ g_mem))
      rr_d = g_int;
  end

  always_comb begin
    sel = 4'b0000;
    if (!hold) begin
      if (res_q[0]) begin
        sel = 4'b0001 << own_q[0];
      end else begin
        if (g_int && (INT_LAT == 0))   sel[0] = 1'b1;
        if (g_mult && (MULT_LAT == 0)) sel[2] = 1'b1;
        if (g_mem && (MEM_LAT == 0))   sel[3] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_q   <= '0;
      own_q   <= '0;
      div_cnt <= '0;
      rr_q    <= 1'b0;
    end else if (i_flush) begin
      res_q   <= '0;
      own_q   <= '0;
      div_cnt <= '0;
    end else begin
      res_q   <= res_d;
      own_q   <= own_d;
      div_cnt <= div_cnt_d;
      rr_q    <= rr_d;
    end
  end

  // A booked slot 0 masks every latency-0 request, so both cannot coincide.
  always_ff @(posedge i_clk) begin
    if (!i_rst) assert (!(res_q[0] && lat0_grant));
  end

  assign o_issue_int  = g_int;
  assign o_issue_mult = g_mult;
  assign o_issue_div  = g_div;
  assign o_issue_mem  = g_mem;
  assign o_cdb_sel    = sel;
  assign o_cdb_valid  = |sel;

`ifdef CDB_SCHED_PERF_EN
  logic denied;
  assign denied = ~hold & (
      (i_ready_div & ~i_div_exec_busy & (div_cnt == '0) & ~g_div)
    | (i_ready_mult & ~g_mult)
    | (i_ready_int & ~g_int)
    | (i_ready_mem & ~g_mem));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush)
      o_conflict_cnt <= '0;
    else if (denied && (o_conflict_cnt != 16'hFFFF))
      o_conflict_cnt <= o_conflict_cnt + 16'd1;
  end
`endif

endmodule
